// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit (8 ops) with zero/parity flags and a wrapping op counter.
// Result registered 2 edges after input transfer; full valid/ready backpressure, 1 op/cycle sustained.
module logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] s2_res;

    // in_ready depends on out_ready only, never on in_valid; forced low during reset.
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = rst_n && (!s1_valid || s1_adv);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        s2_res = s1_a;
        case (s1_op)
            OP_NOT:  s2_res = ~s1_a;
            OP_AND:  s2_res = s1_a & s1_b;
            OP_OR:   s2_res = s1_a | s1_b;
            OP_XOR:  s2_res = s1_a ^ s1_b;
            OP_NAND: s2_res = ~(s1_a & s1_b);
            OP_NOR:  s2_res = ~(s1_a | s1_b);
            OP_XNOR: s2_res = ~(s1_a ^ s1_b);
            default: s2_res = s1_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOT;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_op    <= op_e'(op);
            s1_a     <= a;
            s1_b     <= b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Flags and result hold their last values once the output drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            o         <= s2_res;
            zero      <= (s2_res == '0);
            parity    <= ^s2_res;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_xfer) begin
            op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized and directed bench for logic_unit_pipe against a queue-based reference model.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, parity;
    logic [2:0]  op;
    logic [3:0]  a, b, o;
    logic [7:0]  op_count;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_zero, w_parity;
    logic [2:0]  w_op;
    logic [15:0] w_a, w_b, w_o;
    logic [1:0]  w_op_count;

    logic_unit_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .o(o),
        .zero(zero), .parity(parity), .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(16), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
        .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .o(w_o),
        .zero(w_zero), .parity(w_parity), .op_count(w_op_count)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    int         n_out = 0;
    logic       hold_pending = 1'b0;
    logic [3:0] held_o = '0;
    logic       last_ov = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
        case (f)
            3'd0:    return ~x;
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return x ^ y;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    // One clock of stimulus on the 4-bit unit; handshakes are judged just after the falling edge.
    task automatic step(input logic v, input logic [2:0] f, input logic [3:0] x, input logic [3:0] y,
                        input logic rdy, output logic acc);
        logic [3:0]  e;
        logic [15:0] r;
        @(negedge clk);
        in_valid = v; op = f; a = x; b = y; out_ready = rdy;
        #1;
        last_ov = out_valid;
        check("op_count", 32'(op_count), 32'(n_out % 256));
        check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || rdy));
        if (hold_pending) begin
            check("stall_vld", 32'(out_valid), 32'd1);
            check("stall_o", 32'(o), 32'(held_o));
        end
        if (out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("o", 32'(o), 32'(e));
                check("zero", 32'(zero), 32'(e == 4'd0));
                check("parity", 32'(parity), 32'(^e));
                n_out++;
            end
        end
        acc = v && in_ready;
        if (acc) begin
            r = ref_op(f, {12'b0, x}, {12'b0, y});
            exp_q.push_back(r[3:0]);
        end
        hold_pending = out_valid && !rdy;
        held_o = o;
    endtask

    task automatic send(input logic [2:0] f, input logic [3:0] x, input logic [3:0] y, input logic rdy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, f, x, y, rdy, acc);
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, 4'd0, 4'd0, rdy, acc);
    endtask

    logic        acc;
    logic [15:0] wexp;

    initial begin
        rst_n = 1'b1;
        in_valid = 0; op = 0; a = 0; b = 0; out_ready = 1;
        w_in_valid = 0; w_op = 0; w_a = 0; w_b = 0; w_out_ready = 1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_o", 32'(o), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_parity", 32'(parity), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single NOT with latency probe.
        step(1'b1, 3'b000, 4'b0110, 4'b0000, 1'b1, acc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_edge1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_edge2", 32'(out_valid), 32'd1);
        check("lat_o", 32'(o), 32'b1001);
        idle(2, 1'b1);

        // Back-to-back sweep of ops 001..111.
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 3'(i), 4'b1100, 4'b1010, 1'b1, acc);
            if (i >= 3) check("sweep_vld", 32'(last_ov), 32'd1);
        end
        idle(3, 1'b1);
        check("sweep_count", 32'(op_count), 32'd8);

        // Backpressure: two ops fill the pipe, third must wait.
        send(3'b001, 4'b1111, 4'b0101, 1'b0);
        send(3'b010, 4'b0001, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'b011, 4'b1010, 4'b0110, 1'b0, acc);
            check("bp_block", 32'(acc), 32'd0);
        end
        send(3'b011, 4'b1010, 4'b0110, 1'b1);
        idle(4, 1'b1);

        // Flag corner cases.
        send(3'b011, 4'b1111, 4'b1111, 1'b1);
        send(3'b000, 4'b1110, 4'b0000, 1'b1);
        idle(3, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            step(1'($urandom % 2), 3'($urandom), 4'($urandom), 4'($urandom),
                 1'(($urandom % 4) != 0), acc);
        idle(6, 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);

        // Reset with two ops in flight.
        send(3'b001, 4'b1111, 4'b1111, 1'b0);
        send(3'b111, 4'b0101, 4'b0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_o", 32'(o), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd1);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        n_out = 0;
        hold_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6, 1'b1);

        // 16-bit unit with a 2-bit wrapping counter.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            w_in_valid = 1'b1;
            w_op = (k == 0) ? 3'b000 : 3'($urandom);
            w_a  = (k == 0) ? 16'h00FF : 16'($urandom);
            w_b  = 16'($urandom);
            #1;
            check("w_in_ready", 32'(w_in_ready), 32'd1);
            wexp = ref_op(w_op, w_a, w_b);
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            check("w_vld_early", 32'(w_out_valid), 32'd0);
            @(posedge clk); #1;
            check("w_out_valid", 32'(w_out_valid), 32'd1);
            check("w_o", 32'(w_o), 32'(wexp));
            if (k == 0) check("w_not_ff", 32'(w_o), 32'hFF00);
            check("w_zero", 32'(w_zero), 32'(wexp == 16'd0));
            check("w_parity", 32'(w_parity), 32'(^wexp));
            @(posedge clk); #1;
            check("w_op_count", 32'(w_op_count), 32'((k + 1) % 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
